// File: rtl/axi_read_arbiter.sv
// Round-robin, burst-granular arbiter sharing one AXI4 read port among NUM_PORTS masters.
// One master owns AR and R from arbitration until its RLAST beat; single outstanding burst.
module axi_read_arbiter #(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned ADDR_WIDTH = 25,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                             aclk,
   input  logic                             rst,
   // slave side, port i at [i*W +: W]
   input  logic [NUM_PORTS*ID_WIDTH-1:0]    s_axi_arid,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_axi_araddr,
   input  logic [NUM_PORTS*8-1:0]           s_axi_arlen,
   input  logic [NUM_PORTS*3-1:0]           s_axi_arsize,
   input  logic [NUM_PORTS*2-1:0]           s_axi_arburst,
   input  logic [NUM_PORTS-1:0]             s_axi_arvalid,
   output logic [NUM_PORTS-1:0]             s_axi_arready,
   output logic [NUM_PORTS*ID_WIDTH-1:0]    s_axi_rid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axi_rdata,
   output logic [NUM_PORTS*2-1:0]           s_axi_rresp,
   output logic [NUM_PORTS-1:0]             s_axi_rlast,
   output logic [NUM_PORTS-1:0]             s_axi_rvalid,
   input  logic [NUM_PORTS-1:0]             s_axi_rready,
   // master side
   output logic [ID_WIDTH-1:0]              m_axi_arid,
   output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
   output logic [7:0]                       m_axi_arlen,
   output logic [2:0]                       m_axi_arsize,
   output logic [1:0]                       m_axi_arburst,
   output logic                             m_axi_arlock,
   output logic [3:0]                       m_axi_arcache,
   output logic [2:0]                       m_axi_arprot,
   output logic                             m_axi_arvalid,
   input  logic                             m_axi_arready,
   input  logic [ID_WIDTH-1:0]              m_axi_rid,
   input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
   input  logic [1:0]                       m_axi_rresp,
   input  logic                             m_axi_rlast,
   input  logic                             m_axi_rvalid,
   output logic                             m_axi_rready
);

   localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [GW-1:0]         last_grant_q, last_grant_d;
   logic [GW-1:0]         arb_idx;
   logic                  arb_found;
   logic [NUM_PORTS-1:0]  grant_oh;
   logic                  sel_arvalid;
   logic                  sel_rready;

   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;

   // R payload is broadcast; only the owner sees rvalid/rlast.
   assign s_axi_rid   = {NUM_PORTS{m_axi_rid}};
   assign s_axi_rdata = {NUM_PORTS{m_axi_rdata}};
   assign s_axi_rresp = {NUM_PORTS{m_axi_rresp}};

   // First requester strictly after last_grant, wrapping modulo NUM_PORTS.
   always_comb begin
      arb_idx   = '0;
      arb_found = 1'b0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!arb_found && s_axi_arvalid[i] &&
                (i == (32'(last_grant_q) + k) % NUM_PORTS)) begin
               arb_found = 1'b1;
               arb_idx   = GW'(i);
            end
         end
      end
   end

   always_comb begin
      grant_oh      = '0;
      sel_arvalid   = 1'b0;
      sel_rready    = 1'b0;
      m_axi_arid    = '0;
      m_axi_araddr  = '0;
      m_axi_arlen   = '0;
      m_axi_arsize  = '0;
      m_axi_arburst = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (grant_q == GW'(i)) begin
            grant_oh[i]   = 1'b1;
            sel_arvalid   = s_axi_arvalid[i];
            sel_rready    = s_axi_rready[i];
            m_axi_arid    = s_axi_arid[i*ID_WIDTH +: ID_WIDTH];
            m_axi_araddr  = s_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            m_axi_arlen   = s_axi_arlen[i*8 +: 8];
            m_axi_arsize  = s_axi_arsize[i*3 +: 3];
            m_axi_arburst = s_axi_arburst[i*2 +: 2];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      s_axi_arready = '0;
      s_axi_rvalid  = '0;
      s_axi_rlast   = '0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arb_found) begin
               grant_d = arb_idx;
               state_d = StAddr;
            end
         end
         StAddr: begin
            // A master withdrawing arvalid here just stalls; ownership is kept.
            m_axi_arvalid = sel_arvalid;
            s_axi_arready = grant_oh & {NUM_PORTS{m_axi_arready}};
            if (sel_arvalid && m_axi_arready) begin
               last_grant_d = grant_q;
               state_d      = StData;
            end
         end
         StData: begin
            s_axi_rvalid = grant_oh & {NUM_PORTS{m_axi_rvalid}};
            s_axi_rlast  = grant_oh & {NUM_PORTS{m_axi_rlast}};
            m_axi_rready = sel_rready;
            if (m_axi_rvalid && sel_rready && m_axi_rlast) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_PORTS - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

endmodule
